bcd_xs3_serial_ctrl: RTL

Sequencer for the team's serial BCD-to-Excess-3 converter (Mealy, LSB-first, 4-bit frames, active-low reset_b, same clk).
- Accepts a parallel multi-digit BCD word over a valid/ready handshake.
- Clears the converter, then streams the word bit-serially into it, LSB of the least-significant digit first.
- Gathers the converter's serial output back into a parallel Excess-3 word, presented on a valid/ready output handshake.

---
 rtl/bcd_xs3_serial_ctrl_if.sv | 26 ++
 rtl/bcd_xs3_serial_ctrl.sv | 114 +++++++++++
 2 files changed

// File: rtl/bcd_xs3_serial_ctrl_if.sv
// Parallel word handshake between a BCD producer / Excess-3 consumer and the serial controller.
interface bcd_xs3_serial_ctrl_if #(
    parameter int unsigned NUM_DIGITS = 2
);
    localparam int unsigned DW = 4 * NUM_DIGITS;

    logic [DW-1:0] bcd_in;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] xs3_out;
    logic          out_valid;
    logic          out_ready;
    logic          bcd_err;

    // Producer/consumer side
    modport master (
        output bcd_in, in_valid, out_ready,
        input  in_ready, xs3_out, out_valid, bcd_err
    );

    // Controller side
    modport slave (
        input  bcd_in, in_valid, out_ready,
        output in_ready, xs3_out, out_valid, bcd_err
    );
endinterface

// File: rtl/bcd_xs3_serial_ctrl.sv
// Sequencer for the serial BCD-to-Excess-3 converter: loads a parallel BCD word,
// clears the converter for one cycle, streams the word LSB-first, and gathers the
// Mealy serial result back into a parallel Excess-3 word.
module bcd_xs3_serial_ctrl #(
    parameter int unsigned NUM_DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    bcd_xs3_serial_ctrl_if.slave  bus,
    output logic                  busy,
    output logic                  conv_B_in,
    output logic                  conv_reset_b,
    input  logic                  conv_B_out
);
    localparam int unsigned DW = 4 * NUM_DIGITS;
    localparam int unsigned CW = $clog2(DW);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [DW-1:0] shift_q, shift_d;
    logic [DW-1:0] result_q, result_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] xs3_q, xs3_d;
    logic          err_q, err_d;
    logic          err_pend_q, err_pend_d;
    logic          digit_err;
    logic          accept;

    // Flag any input digit above 9
    always_comb begin
        digit_err = 1'b0;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (bus.bcd_in[4*i +: 4] > 4'd9) begin
                digit_err = 1'b1;
            end
        end
    end

    assign bus.in_ready  = (state_q == IDLE) | ((state_q == DONE) & bus.out_ready);
    assign accept        = bus.in_valid & bus.in_ready;
    assign bus.out_valid = (state_q == DONE);
    assign bus.xs3_out   = xs3_q;
    assign bus.bcd_err   = err_q;
    assign busy          = (state_q != IDLE);
    // Converter is held cleared through our reset and for the one CLEAR cycle
    assign conv_reset_b  = ~(reset | (state_q == CLEAR));
    assign conv_B_in     = (state_q == SHIFT) & shift_q[0];

    // State register and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            result_q   <= '0;
            cnt_q      <= '0;
            xs3_q      <= '0;
            err_q      <= 1'b0;
            err_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            result_q   <= result_d;
            cnt_q      <= cnt_d;
            xs3_q      <= xs3_d;
            err_q      <= err_d;
            err_pend_q <= err_pend_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        result_d   = result_q;
        cnt_d      = cnt_q;
        xs3_d      = xs3_q;
        err_d      = err_q;
        err_pend_d = err_pend_q;
        case (state_q)
            IDLE, DONE: begin
                // DONE retires the held result and may take the next word on the same edge
                if (accept) begin
                    shift_d    = bus.bcd_in;
                    err_pend_d = digit_err;
                    state_d    = CLEAR;
                end else if ((state_q == DONE) && bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            CLEAR: begin
                cnt_d   = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                shift_d  = shift_q >> 1;
                result_d = {conv_B_out, result_q[DW-1:1]};
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(DW - 1)) begin
                    xs3_d   = result_d;
                    err_d   = err_pend_q;
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule
